ads8528_emulator: RTL

//   Synthesizable behavioural model of the ADS8528 parallel-interface responder: accepts config writes, conversion

---
 rtl/ads8528_emulator.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/ads8528_emulator.sv
// ADS8528 parallel-interface responder (parallel bus, software mode).
// Answers the ADC driver's config writes, conversion starts and read
// strobes with the same busy/db timing as the real part. Sample data is a
// deterministic {channel, conversion count} pattern, so a captured stream
// can be checked word by word without an ADC fitted.
module ads8528_emulator #(
  parameter int NUM_CH      = 8,
  parameter int CONV_CYCLES = 20,
  parameter int CFG_WORDS   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cs_n,
  input  logic        rd_n,
  input  logic        wr_n,
  input  logic [3:0]  convst,
  inout  wire  [15:0] db,
  output logic        busy,
  output logic [31:0] cfg_word,
  output logic [12:0] conv_count,
  output logic        overrun
);

  localparam int CNT_W = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;
  localparam int IDX_W = (CFG_WORDS > 1) ? $clog2(CFG_WORDS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CONV_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(CFG_WORDS - 1);
  localparam logic [2:0]       PTR_LAST = 3'(NUM_CH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CONV  = 2'd1,
    READY = 2'd2
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [2:0]        ptr;
  logic [IDX_W-1:0]  idx;
  logic              oe;

  logic              rd_n_p1;
  logic              wr_n_p1;
  logic [3:0]        convst_p1;

  logic [15:0]       data_reg;
  logic [15:0]       shadow [CFG_WORDS];
  logic [31:0]       cfg_next;
  logic [15:0]       db_out;

  logic              rd_fall;
  logic              wr_rise;
  logic              cv_rise;
  logic              wr_ok;

  // Channel k of the current conversion carries its index in the top bits
  // and the (already incremented) conversion count below.
  function automatic logic [15:0] sample_word(input logic [2:0] ch,
                                              input logic [12:0] count);
    return {ch, count};
  endfunction

  // Strobe edges compare the registered level against the level seen now,
  // so an edge is acted on in the same clock that first samples it. A read
  // only counts with the chip selected and no write strobe active (writes
  // win when both strobes are low).
  assign rd_fall = rd_n_p1 & ~rd_n & ~cs_n & wr_n;
  assign wr_rise = ~wr_n_p1 & wr_n & ~cs_n;
  assign cv_rise = |(convst & ~convst_p1);
  assign wr_ok   = wr_rise && (state != CONV);

  // Assemble the config word: earlier writes land in the upper halves.
  always_comb begin
    cfg_next = '0;
    for (int i = 0; i < CFG_WORDS - 1; i++) begin
      cfg_next = {cfg_next[15:0], shadow[i]};
    end
    cfg_next = {cfg_next[15:0], db};
  end

  // Bus value: an idle part returns zeros, otherwise the last word latched.
  always_comb begin
    db_out = (state == IDLE) ? 16'h0000 : data_reg;
  end

  assign db = oe ? db_out : {16{1'bz}};

  // Control path: edge history, conversion sequencer, read pointer, write
  // word index, config word, counters and the sticky overrun flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_n_p1    <= 1'b1;
      wr_n_p1    <= 1'b1;
      convst_p1  <= 4'h0;
      state      <= IDLE;
      busy       <= 1'b0;
      cnt        <= '0;
      ptr        <= 3'd0;
      idx        <= '0;
      oe         <= 1'b0;
      cfg_word   <= 32'h0;
      conv_count <= 13'd0;
      overrun    <= 1'b0;
    end else begin
      // stage p1: registered copies of the strobes for edge detection
      rd_n_p1   <= rd_n;
      wr_n_p1   <= wr_n;
      convst_p1 <= convst;
      oe        <= ~cs_n & ~rd_n & wr_n;

      case (state)
        IDLE: begin
          if (cv_rise) begin
            state <= CONV;
            busy  <= 1'b1;
            cnt   <= '0;
          end
        end
        CONV: begin
          // A start or a read during conversion is a driver timing error;
          // neither disturbs the conversion already under way.
          if (cv_rise || rd_fall) begin
            overrun <= 1'b1;
          end
          if (cnt == CNT_LAST) begin
            state      <= READY;
            busy       <= 1'b0;
            conv_count <= conv_count + 13'd1;
            ptr        <= 3'd0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        READY: begin
          // A new start takes precedence over a read in the same clock.
          if (cv_rise) begin
            state <= CONV;
            busy  <= 1'b1;
            cnt   <= '0;
          end else if (rd_fall) begin
            ptr <= (ptr == PTR_LAST) ? 3'd0 : ptr + 3'd1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase

      if (wr_ok) begin
        if (idx == IDX_LAST) begin
          cfg_word <= cfg_next;
          idx      <= '0;
        end else begin
          idx <= idx + 1'b1;
        end
      end
    end
  end

  // Data path: read data register and config shadow words (not reset).
  always_ff @(posedge clk) begin
    if (state == READY && rd_fall && !cv_rise) begin
      data_reg <= sample_word(ptr, conv_count);
    end
    if (wr_ok) begin
      shadow[idx] <= db;
    end
  end

endmodule
